// File: rtl/ravenslofty_chess_core.sv
// ravenslofty_chess_core: quad-SPI chess board store.
// A host clocks 4-bit nibbles in (sdi) and out (sdo). Commands: 0x01 WRITE,
// 0x02 READ, 0x03 CLEAR. The board holds 64 squares of 4-bit piece codes.
// Optional feature macro: CHESS_CLEAR_EN enables the 0x03 CLEAR command;
// without it 0x03 is treated like any other unknown command.
`timescale 1ns/1ps
module ravenslofty_chess_core (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_sck,
  input  logic       i_cs_n,
  input  logic [3:0] i_sdi,
  output logic [3:0] o_sdo
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    CMD_HI  = 4'd1,
    CMD_LO  = 4'd2,
    ADDR_HI = 4'd3,
    ADDR_LO = 4'd4,
    WDATA   = 4'd5,
    TURN    = 4'd6,
    RDATA   = 4'd7,
    IGNORE  = 4'd8
  } state_t;

  logic       r_sck_meta, r_sck_sync, r_sck_prev;
  logic       r_cs_meta, r_cs_sync;
  logic [3:0] r_sdi_meta, r_sdi_sync;
  state_t     r_state;
  logic [3:0] r_cmd_hi;
  logic       r_is_read;
  logic [1:0] r_addr_hi;
  logic [5:0] r_ptr;
  logic       r_turn;
  logic [3:0] r_sdo;
  logic [3:0] r_board [64];
  logic       w_sck_rise;

  assign w_sck_rise = r_sck_sync & ~r_sck_prev;
  assign o_sdo      = r_sdo;

  // Bring the host-domain pins into clk via two-flop synchronisers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sck_meta <= 1'b0;
      r_sck_sync <= 1'b0;
      r_sck_prev <= 1'b0;
      r_cs_meta  <= 1'b1;
      r_cs_sync  <= 1'b1;
      r_sdi_meta <= 4'd0;
      r_sdi_sync <= 4'd0;
    end else begin
      r_sck_meta <= i_sck;
      r_sck_sync <= r_sck_meta;
      r_sck_prev <= r_sck_sync;
      r_cs_meta  <= i_cs_n;
      r_cs_sync  <= r_cs_meta;
      r_sdi_meta <= i_sdi;
      r_sdi_sync <= r_sdi_meta;
    end
  end

  // Transaction FSM, square pointer, board storage and read-data register.
  // A deselect has priority over a same-cycle sck rise, so that nibble is dropped.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_cmd_hi  <= 4'd0;
      r_is_read <= 1'b0;
      r_addr_hi <= 2'd0;
      r_ptr     <= 6'd0;
      r_turn    <= 1'b0;
      r_sdo     <= 4'd0;
      for (int i = 0; i < 64; i++) begin
        r_board[i] <= 4'd0;
      end
    end else if (r_cs_sync) begin
      r_state <= IDLE;
      r_sdo   <= 4'd0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state <= CMD_HI;
          r_sdo   <= 4'd0;
        end
        CMD_HI: begin
          if (w_sck_rise) begin
            r_cmd_hi <= r_sdi_sync;
            r_state  <= CMD_LO;
          end
        end
        CMD_LO: begin
          if (w_sck_rise) begin
            case ({r_cmd_hi, r_sdi_sync})
              8'h01: begin
                r_is_read <= 1'b0;
                r_state   <= ADDR_HI;
              end
              8'h02: begin
                r_is_read <= 1'b1;
                r_state   <= ADDR_HI;
              end
`ifdef CHESS_CLEAR_EN
              8'h03: begin
                for (int i = 0; i < 64; i++) begin
                  r_board[i] <= 4'd0;
                end
                r_state <= IGNORE;
              end
`endif
              default: r_state <= IGNORE;
            endcase
          end
        end
        ADDR_HI: begin
          // Address bits 7:6 are don't-care; only 5:4 are kept.
          if (w_sck_rise) begin
            r_addr_hi <= r_sdi_sync[1:0];
            r_state   <= ADDR_LO;
          end
        end
        ADDR_LO: begin
          if (w_sck_rise) begin
            r_ptr   <= {r_addr_hi, r_sdi_sync};
            r_turn  <= 1'b0;
            r_state <= r_is_read ? TURN : WDATA;
          end
        end
        WDATA: begin
          if (w_sck_rise) begin
            r_board[r_ptr] <= r_sdi_sync;
            r_ptr          <= r_ptr + 6'd1;
          end
        end
        TURN: begin
          // Second turnaround rise launches the first read nibble.
          if (w_sck_rise) begin
            if (r_turn) begin
              r_sdo   <= r_board[r_ptr];
              r_state <= RDATA;
            end else begin
              r_turn <= 1'b1;
            end
          end
        end
        RDATA: begin
          // Host has sampled the current nibble on this rise; present the next.
          if (w_sck_rise) begin
            r_sdo <= r_board[r_ptr + 6'd1];
            r_ptr <= r_ptr + 6'd1;
          end
        end
        IGNORE: begin
          r_sdo <= 4'd0;
        end
        default: begin
          r_state <= IDLE;
          r_sdo   <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ravenslofty_chess_core.sv
// Directed self-checking bench for ravenslofty_chess_core.
`timescale 1ns/1ps
module tb_ravenslofty_chess_core;

  logic       clk = 1'b0;
  logic       rst;
  logic       sck;
  logic       cs_n;
  logic [3:0] sdi;
  logic [3:0] sdo;
  logic [3:0] q;
  int         errors = 0;
  int         checks = 0;

  ravenslofty_chess_core dut (
    .i_clk (clk),
    .i_rst (rst),
    .i_sck (sck),
    .i_cs_n(cs_n),
    .i_sdi (sdi),
    .o_sdo (sdo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One sck period: 4 clk low with sdi set, sample sdo, then 4 clk high.
  task automatic nib(input logic [3:0] d, output logic [3:0] s);
    sdi = d;
    #40;
    s = sdo;
    sck = 1'b1;
    #40;
    sck = 1'b0;
  endtask

  task automatic begin_tx();
    cs_n = 1'b0;
    #40;
  endtask

  task automatic end_tx();
    #40;
    cs_n = 1'b1;
    #80;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [3:0] s;
    nib(b[7:4], s);
    nib(b[3:0], s);
  endtask

  task automatic write1(input logic [5:0] a, input logic [3:0] d);
    logic [3:0] s;
    begin_tx();
    send_byte(8'h01);
    send_byte({2'b00, a});
    nib(d, s);
    end_tx();
  endtask

  task automatic read_start(input logic [5:0] a);
    logic [3:0] s;
    begin_tx();
    send_byte(8'h02);
    send_byte({2'b00, a});
    nib(4'h0, s);
    nib(4'h0, s);
  endtask

  initial begin
    rst  = 1'b1;
    sck  = 1'b0;
    cs_n = 1'b1;
    sdi  = 4'h0;
    #2;
    #20;
    rst = 1'b0;
    #20;
    chk("reset_idle_sdo", sdo, 4'h0);

    // Whole board empty after reset
    read_start(6'd0);
    for (int i = 0; i < 64; i++) begin
      nib(4'h0, q);
      chk("reset_board", q, 4'h0);
    end
    end_tx();
    chk("idle_sdo_after_read", sdo, 4'h0);

    // White king on e1
    write1(6'd4, 4'h6);
    read_start(6'd4);
    nib(4'h0, q);
    chk("e1_king", q, 4'h6);
    end_tx();

    // Write across the 63 -> 0 wrap
    begin_tx();
    send_byte(8'h01);
    send_byte(8'h3F);
    nib(4'hE, q);
    nib(4'h4, q);
    end_tx();
    read_start(6'd63);
    nib(4'h0, q);
    chk("sq63", q, 4'hE);
    nib(4'h0, q);
    chk("sq0_read_wrap", q, 4'h4);
    end_tx();
    read_start(6'd0);
    nib(4'h0, q);
    chk("sq0_direct", q, 4'h4);
    end_tx();

    // Abort after one address nibble, then a fresh write must parse cleanly
    begin_tx();
    send_byte(8'h01);
    nib(4'h1, q);
    end_tx();
    write1(6'h11, 4'h5);
    read_start(6'h10);
    nib(4'h0, q);
    chk("abort_sq10", q, 4'h0);
    nib(4'h0, q);
    chk("after_abort_sq11", q, 4'h5);
    end_tx();

    // Unknown command: sdo quiet, board untouched
    begin_tx();
    send_byte(8'h7F);
    for (int i = 0; i < 10; i++) begin
      nib(4'h9, q);
      chk("unknown_sdo", q, 4'h0);
    end
    end_tx();
    read_start(6'd4);
    nib(4'h0, q);
    chk("unknown_board_sq4", q, 4'h6);
    end_tx();

    // CLEAR
    write1(6'd5, 4'hA);
    begin_tx();
    send_byte(8'h03);
    nib(4'h5, q);
    nib(4'h5, q);
    end_tx();
    read_start(6'd4);
    nib(4'h0, q);
`ifdef CHESS_CLEAR_EN
    chk("clear_sq4", q, 4'h0);
`else
    chk("clear_sq4", q, 4'h6);
`endif
    nib(4'h0, q);
`ifdef CHESS_CLEAR_EN
    chk("clear_sq5", q, 4'h0);
`else
    chk("clear_sq5", q, 4'hA);
`endif
    end_tx();

    // Reset in the middle of a READ
    write1(6'd7, 4'hC);
    read_start(6'd7);
    #40;
    chk("mid_read_sdo", sdo, 4'hC);
    rst = 1'b1;
    #10;
    chk("rst_mid_read_sdo", sdo, 4'h0);
    rst  = 1'b0;
    cs_n = 1'b1;
    #80;
    read_start(6'd7);
    nib(4'h0, q);
    chk("rst_cleared_sq7", q, 4'h0);
    end_tx();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
